// File: rtl/mux4_rr_select.sv
// Round-robin arbiter producing the 2-bit select, one-hot grant, valid and
// hold-limit timeout for a downstream 4:1 mux. All outputs are registered.
module mux4_rr_select #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [1:0]       ptr_reg;
    logic [CNT_W-1:0] hold_reg;
    logic [1:0]       sel_reg;
    logic [3:0]       gnt_reg;
    logic             valid_reg;
    logic             timeout_reg;

    // Requests rotated so that bit 0 is the channel the pointer favours.
    logic [3:0] rot_req;
    logic [1:0] pick_off;
    logic [1:0] pick_next;
    logic       at_limit;
    logic       owner_req;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot_req[gi] = req[ptr_reg + 2'(gi)];
    end

    always_comb begin
        pick_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick_off = 2'(i);
            end
        end
    end

    assign pick_next = ptr_reg + pick_off;
    assign at_limit  = (hold_reg == CNT_W'(HOLD_MAX));
    assign owner_req = req[sel_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= 2'd0;
            hold_reg    <= '0;
            sel_reg     <= 2'd0;
            gnt_reg     <= 4'b0000;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout_reg <= 1'b0;
                    if (en && (req != 4'b0000)) begin
                        state_reg <= GRANT;
                        sel_reg   <= pick_next;
                        gnt_reg   <= 4'b0001 << pick_next;
                        valid_reg <= 1'b1;
                        hold_reg  <= CNT_W'(1);
                        ptr_reg   <= pick_next + 2'd1;
                    end else begin
                        gnt_reg   <= 4'b0000;
                        valid_reg <= 1'b0;
                    end
                end
                GRANT: begin
                    if (rel || !owner_req || at_limit) begin
                        state_reg   <= IDLE;
                        gnt_reg     <= 4'b0000;
                        valid_reg   <= 1'b0;
                        hold_reg    <= '0;
                        // Only a pure hold-limit exit reaches here with rel=0 and req held.
                        timeout_reg <= !rel && owner_req;
                    end else begin
                        timeout_reg <= 1'b0;
                        if (!at_limit) begin
                            hold_reg <= hold_reg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    gnt_reg     <= 4'b0000;
                    valid_reg   <= 1'b0;
                    timeout_reg <= 1'b0;
                end
            endcase
        end
    end

    assign sel     = sel_reg;
    assign gnt     = gnt_reg;
    assign valid   = valid_reg;
    assign timeout = timeout_reg;

endmodule
